// File: rtl/SystemPeripheral_Pkg.sv
// Shared system-peripheral bus definitions: request struct, address layout,
// per-peripheral IDs and register offsets, and address-match helpers.
package SystemPeripheral_Pkg;

  localparam int SP_ID_LEN     = 4;
  localparam int SP_OFFSET_LEN = 2;
  localparam int SP_ADDR_LEN   = SP_ID_LEN + SP_OFFSET_LEN;
  localparam int SP_DATA_LEN   = 32;

  typedef struct packed {
    logic [SP_ADDR_LEN-1:0] raddr;
    logic [SP_ADDR_LEN-1:0] waddr;
    logic [SP_DATA_LEN-1:0] wdata;
  } sys_peripheral_t;

  localparam logic [SP_ID_LEN-1:0] SYS_TIMER_ID = 4'd2;

  localparam logic [SP_OFFSET_LEN-1:0] SYS_TIMER_MTIME_LO    = 2'd0;
  localparam logic [SP_OFFSET_LEN-1:0] SYS_TIMER_MTIME_HI    = 2'd1;
  localparam logic [SP_OFFSET_LEN-1:0] SYS_TIMER_MTIMECMP_LO = 2'd2;
  localparam logic [SP_OFFSET_LEN-1:0] SYS_TIMER_MTIMECMP_HI = 2'd3;

  // Full-address match: peripheral ID in the upper bits, register offset below.
  function automatic logic RAddrEq(input sys_peripheral_t req,
                                   input logic [SP_ID_LEN-1:0] id,
                                   input logic [SP_OFFSET_LEN-1:0] off);
    return req.raddr == {id, off};
  endfunction

  function automatic logic WAddrEq(input sys_peripheral_t req,
                                   input logic [SP_ID_LEN-1:0] id,
                                   input logic [SP_OFFSET_LEN-1:0] off);
    return req.waddr == {id, off};
  endfunction

endpackage

// File: rtl/sys_timer_pkg.sv
// Timer-local constants and helpers: reset values, prescaler range handling,
// and the 32-bit half-replace used by all register writes.
package sys_timer_pkg;

  localparam logic [63:0] MTIME_RST    = 64'd0;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int unsigned TICK_DIV_MAX = 65535;

  // Out-of-range divisors saturate into 1..TICK_DIV_MAX.
  function automatic int unsigned div_clamp(input int div);
    if (div < 1) return 1;
    if (div > int'(TICK_DIV_MAX)) return TICK_DIV_MAX;
    return int'(div);
  endfunction

  function automatic int unsigned div_cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic [63:0] set_half(input logic [63:0] cur,
                                           input logic        hi,
                                           input logic [31:0] val);
    logic [63:0] res;
    res = cur;
    if (hi) res[63:32] = val;
    else    res[31:0]  = val;
    return res;
  endfunction

endpackage

// File: rtl/sys_timer_tick_divider.sv
// Prescaler for mtime: one-cycle tick every TICK_DIV clocks, no jitter.
// With TICK_DIV == 1 the tick is tied high and the counter stays at zero.
module tick_divider
  import sys_timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV  = div_clamp(TICK_DIV);
  localparam int unsigned CW   = div_cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  generate
    if (DIV == 1) begin : g_bypass
      assign tick = 1'b1;
    end else begin : g_count
      assign tick = (div_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped 64-bit mtime/mtimecmp timer with a level machine-timer interrupt.
// SYS_TIMER_READ_SNAPSHOT_EN: MTIME_LO reads latch mtime[63:32] for the next MTIME_HI read.
module sys_timer
  import SystemPeripheral_Pkg::*;
  import sys_timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  sys_peripheral_t sys_share,
  input  logic            ren,
  input  logic            wen,
  output logic [31:0]     rdata,
  output logic            timer_irq
);

  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp_nxt;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        rd_mtime_lo;
  logic        rd_mtime_hi;
  logic        rd_cmp_lo;
  logic        rd_cmp_hi;
  logic [31:0] mtime_hi_view;
  logic [31:0] rd_val;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wr_mtime_lo = wen && WAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIME_LO);
  assign wr_mtime_hi = wen && WAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIME_HI);
  assign wr_cmp_lo   = wen && WAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIMECMP_LO);
  assign wr_cmp_hi   = wen && WAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIMECMP_HI);

  assign rd_mtime_lo = ren && RAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIME_LO);
  assign rd_mtime_hi = ren && RAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIME_HI);
  assign rd_cmp_lo   = ren && RAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIMECMP_LO);
  assign rd_cmp_hi   = ren && RAddrEq(sys_share, SYS_TIMER_ID, SYS_TIMER_MTIMECMP_HI);

  // A half write freezes the other half for that cycle, and swallows any tick.
  always_comb begin
    mtime_nxt = mtime;
    if (wr_mtime_lo) begin
      mtime_nxt = set_half(mtime, 1'b0, sys_share.wdata);
    end else if (wr_mtime_hi) begin
      mtime_nxt = set_half(mtime, 1'b1, sys_share.wdata);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_nxt = mtimecmp;
    if (wr_cmp_lo) begin
      mtimecmp_nxt = set_half(mtimecmp, 1'b0, sys_share.wdata);
    end else if (wr_cmp_hi) begin
      mtimecmp_nxt = set_half(mtimecmp, 1'b1, sys_share.wdata);
    end
  end

`ifdef SYS_TIMER_READ_SNAPSHOT_EN
  logic [31:0] hi_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_shadow <= '0;
    end else if (rd_mtime_lo) begin
      hi_shadow <= mtime[63:32];
    end
  end

  assign mtime_hi_view = hi_shadow;
`else
  assign mtime_hi_view = mtime[63:32];
`endif

  // Reads see the registers before any same-cycle write lands.
  always_comb begin
    rd_val = '0;
    if (rd_mtime_lo) begin
      rd_val = mtime[31:0];
    end else if (rd_mtime_hi) begin
      rd_val = mtime_hi_view;
    end else if (rd_cmp_lo) begin
      rd_val = mtimecmp[31:0];
    end else if (rd_cmp_hi) begin
      rd_val = mtimecmp[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= MTIME_RST;
      mtimecmp  <= MTIMECMP_RST;
      rdata     <= '0;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      timer_irq <= (mtime >= mtimecmp);
      if (ren) begin
        rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_sys_timer.sv
// Directed plus randomized checks of sys_timer (TICK_DIV 4 and 1 instances)
// against a cycle-level behavioural model of the register rules.
module tb_sys_timer;
  import SystemPeripheral_Pkg::*;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
`ifdef SYS_TIMER_READ_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  sys_peripheral_t bus;
  logic [1:0]      ren;
  logic [1:0]      wen;
  logic [31:0]     rdata_a;
  logic [31:0]     rdata_b;
  logic            irq_a;
  logic            irq_b;

  int total = 0;
  int bad   = 0;

  // Reference state per instance (0: TICK_DIV=4, 1: TICK_DIV=1).
  longint unsigned m_time[2];
  longint unsigned m_cmp[2];
  int unsigned     m_k[2];
  logic [31:0]     m_rdata[2];
  logic [31:0]     m_shadow[2];
  logic            m_irq[2];

  always #5 clk = ~clk;

  sys_timer #(.TICK_DIV(DIV_A)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .sys_share (bus),
    .ren       (ren[0]),
    .wen       (wen[0]),
    .rdata     (rdata_a),
    .timer_irq (irq_a)
  );

  sys_timer #(.TICK_DIV(DIV_B)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .sys_share (bus),
    .ren       (ren[1]),
    .wen       (wen[1]),
    .rdata     (rdata_b),
    .timer_irq (irq_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: one post-reset edge k ticks when k mod div == div-1; reads return
  // pre-edge values; a write to either mtime half suppresses that edge's increment.
  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      longint unsigned t;
      longint unsigned c;
      int unsigned     div;
      logic [1:0]      ro;
      logic [1:0]      wo;
      bit              tk;
      div = (d == 0) ? DIV_A : DIV_B;
      if (rst) begin
        m_time[d] = 0; m_cmp[d] = '1; m_k[d] = 0;
        m_rdata[d] = '0; m_shadow[d] = '0; m_irq[d] = 1'b0;
      end else begin
        t  = m_time[d];
        c  = m_cmp[d];
        tk = ((m_k[d] % div) == div - 1);
        m_k[d]++;
        m_irq[d] = (t >= c);
        ro = bus.raddr[1:0];
        wo = bus.waddr[1:0];
        if (ren[d]) begin
          case (ro)
            2'd0: begin m_rdata[d] = t[31:0]; m_shadow[d] = t[63:32]; end
            2'd1: m_rdata[d] = SNAP ? m_shadow[d] : t[63:32];
            2'd2: m_rdata[d] = c[31:0];
            default: m_rdata[d] = c[63:32];
          endcase
        end
        if (wen[d] && wo == 2'd0)      m_time[d] = {t[63:32], bus.wdata};
        else if (wen[d] && wo == 2'd1) m_time[d] = {bus.wdata, t[31:0]};
        else if (tk)                   m_time[d] = t + 1;
        if (wen[d] && wo == 2'd2)      m_cmp[d] = {c[63:32], bus.wdata};
        else if (wen[d] && wo == 2'd3) m_cmp[d] = {bus.wdata, c[31:0]};
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("rdata_a", {32'd0, rdata_a}, {32'd0, m_rdata[0]});
    check("irq_a",   {63'd0, irq_a},   {63'd0, m_irq[0]});
    check("rdata_b", {32'd0, rdata_b}, {32'd0, m_rdata[1]});
    check("irq_b",   {63'd0, irq_b},   {63'd0, m_irq[1]});
  endtask

  task automatic wr(input int d, input logic [1:0] off, input logic [31:0] v);
    ren = '0; wen = '0; wen[d] = 1'b1;
    bus.waddr = {SYS_TIMER_ID, off};
    bus.wdata = v;
    tick_clk();
    wen = '0;
  endtask

  task automatic rd(input int d, input logic [1:0] off);
    ren = '0; wen = '0; ren[d] = 1'b1;
    bus.raddr = {SYS_TIMER_ID, off};
    tick_clk();
    ren = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] v;
    rst = 1'b1; ren = '0; wen = '0; bus = '0;
    tick_clk();
    tick_clk();
    check("reset_rdata", {32'd0, rdata_a}, 64'd0);
    check("reset_irq",   {63'd0, irq_b},   64'd0);
    rst = 1'b0;

    // Prescaled count: 40 edges at TICK_DIV=4 gives 10.
    for (int i = 0; i < 40; i++) tick_clk();
    rd(0, SYS_TIMER_MTIME_LO);
    check("div4_count", {32'd0, rdata_a}, 64'd10);

    // Compare rise and fall on the undivided instance.
    wr(1, SYS_TIMER_MTIME_LO, 32'd0);
    wr(1, SYS_TIMER_MTIMECMP_HI, 32'd0);
    wr(1, SYS_TIMER_MTIMECMP_LO, 32'd20);
    n = 0;
    while (irq_b !== 1'b1 && n < 60) begin tick_clk(); n++; end
    check("irq_rise_delay", 64'(n), 64'd19);
    wr(1, SYS_TIMER_MTIMECMP_LO, 32'd1000);
    check("irq_hold_on_cmp_write", {63'd0, irq_b}, 64'd1);
    tick_clk();
    check("irq_fall", {63'd0, irq_b}, 64'd0);

    // Low-to-high carry, then full 64-bit wrap.
    wr(1, SYS_TIMER_MTIME_HI, 32'd0);
    wr(1, SYS_TIMER_MTIME_LO, 32'hFFFF_FFFF);
    tick_clk();
    rd(1, SYS_TIMER_MTIME_LO);
    rd(1, SYS_TIMER_MTIME_HI);
    check("carry_hi", {32'd0, rdata_b}, 64'd1);
    wr(1, SYS_TIMER_MTIME_HI, 32'hFFFF_FFFF);
    wr(1, SYS_TIMER_MTIME_LO, 32'hFFFF_FFFF);
    check("irq_near_wrap", {63'd0, irq_b}, 64'd1);
    tick_clk();
    check("irq_at_all_ones", {63'd0, irq_b}, 64'd1);
    tick_clk();
    check("irq_after_wrap", {63'd0, irq_b}, 64'd0);
    rd(1, SYS_TIMER_MTIME_LO);
    check("wrap_lo", {32'd0, rdata_b}, 64'd1);

    // Write coinciding with a prescaler tick wins; no increment.
    n = 0;
    while ((m_k[0] % DIV_A) != DIV_A - 1 && n < 8) begin tick_clk(); n++; end
    wr(0, SYS_TIMER_MTIME_LO, 32'd5);
    rd(0, SYS_TIMER_MTIME_LO);
    check("write_beats_tick", {32'd0, rdata_a}, 64'd5);
    wr(1, SYS_TIMER_MTIME_LO, 32'd5);
    rd(1, SYS_TIMER_MTIME_LO);
    check("write_beats_tick_div1", {32'd0, rdata_b}, 64'd5);

    // LO then HI read across a carry.
    wr(1, SYS_TIMER_MTIME_HI, 32'd0);
    wr(1, SYS_TIMER_MTIME_LO, 32'hFFFF_FFFF);
    rd(1, SYS_TIMER_MTIME_LO);
    check("snap_lo", {32'd0, rdata_b}, 64'hFFFF_FFFF);
    rd(1, SYS_TIMER_MTIME_HI);
    check("snap_hi", {32'd0, rdata_b}, SNAP ? 64'd0 : 64'd1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        ren[d] = ($urandom_range(0, 1) == 0);
        wen[d] = ($urandom_range(0, 3) == 0);
      end
      bus.raddr = {SYS_TIMER_ID, 2'($urandom_range(0, 3))};
      bus.waddr = {SYS_TIMER_ID, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 3))
        0: v = 32'($urandom_range(0, 63));
        1: v = 32'hFFFF_FFFF;
        2: v = 32'd0;
        default: v = $urandom;
      endcase
      bus.wdata = v;
      tick_clk();
    end
    ren = '0; wen = '0;

    // Reset with writes pending: writes dropped, all state back to reset.
    rst = 1'b1;
    wen = 2'b11;
    bus.waddr = {SYS_TIMER_ID, SYS_TIMER_MTIMECMP_LO};
    bus.wdata = 32'd7;
    tick_clk();
    check("rst_rdata_a", {32'd0, rdata_a}, 64'd0);
    check("rst_irq_b", {63'd0, irq_b}, 64'd0);
    rst = 1'b0;
    wen = '0;
    rd(0, SYS_TIMER_MTIMECMP_LO);
    check("rst_cmp_lo", {32'd0, rdata_a}, 64'hFFFF_FFFF);
    rd(0, SYS_TIMER_MTIME_LO);
    check("rst_mtime_lo", {32'd0, rdata_a}, 64'd0);
    rd(1, SYS_TIMER_MTIMECMP_HI);
    check("rst_cmp_hi", {32'd0, rdata_b}, 64'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
